// File: rtl/si5340_cfg_sequencer_if.sv
// si5340_cfg_sequencer_if: byte stream from the config sequencer to the
// Si5340 I2C byte master (valid/ready with first/last framing, NACK back).
interface si5340_cfg_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tfirst;
  logic                  tlast;
  logic                  nack;

  modport master (output tdata, tvalid, tfirst, tlast, input tready, nack);
  modport slave  (input tdata, tvalid, tfirst, tlast, output tready, nack);
endinterface

// File: rtl/si5340_cfg_sequencer.sv
// si5340_cfg_sequencer: walks the Si5340 configuration ROM and emits each
// 24-bit entry as one three-byte write transaction (MSB first) on the byte
// stream, with a settle pause after the preamble word.
// Build option: define CFG_PAUSE_EN to build the settle pause state and its
// 32-bit counter; without it the pause is skipped (bring-up/simulation only).
module si5340_cfg_sequencer #(
  parameter int MEM_WIDTH        = 24,
  parameter int DATA_WIDTH       = 8,
  parameter int WORD_NUMBER      = 326,
  parameter int ADDR_W           = $clog2(WORD_NUMBER),
  parameter int PAUSE_AFTER_WORD = 2,
  parameter int PAUSE_CYCLES     = 37_500_000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic [ADDR_W-1:0]     rom_addr_o,
  input  logic [MEM_WIDTH-1:0]  rom_data_i,
  si5340_cfg_sequencer_if.master m,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  // Reject parameter sets the datapath cannot represent.
  if (MEM_WIDTH != 3 * DATA_WIDTH || WORD_NUMBER < 1 || WORD_NUMBER > (1 << ADDR_W) ||
      PAUSE_AFTER_WORD < 0 || PAUSE_AFTER_WORD >= WORD_NUMBER || PAUSE_CYCLES < 1) begin : g_param_check
    $error("si5340_cfg_sequencer: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, LOAD, LATCH, SEND, PAUSE, DONE, ERROR} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORD_NUMBER - 1);

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      idx_q, idx_d, addr_d;
  logic [1:0]             bcnt_q, bcnt_d;
  logic [MEM_WIDTH-1:0]   word_q;
  logic [DATA_WIDTH-1:0]  tdata_d;
  logic                   tvalid_d, tfirst_d, tlast_d, done_d, err_d;
  logic                   busy, word_end;

`ifdef CFG_PAUSE_EN
  localparam logic [ADDR_W-1:0] PAUSE_IDX  = ADDR_W'(PAUSE_AFTER_WORD);
  localparam logic [31:0]       PAUSE_LOAD = 32'(PAUSE_CYCLES - 1);
  logic [31:0] pcnt_q, pcnt_d;
`endif

  assign busy   = !(state_q inside {IDLE, DONE, ERROR});
  assign busy_o = busy;

  // Next state and next values of every registered output.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = rom_addr_o;
    bcnt_d   = bcnt_q;
    tdata_d  = m.tdata;
    tvalid_d = m.tvalid;
    tfirst_d = m.tfirst;
    tlast_d  = m.tlast;
    done_d   = done_o;
    err_d    = err_o;
    word_end = 1'b0;
`ifdef CFG_PAUSE_EN
    pcnt_d   = pcnt_q;
`endif
    if (busy && m.nack) begin
      // NACK wins over a handshake on the same edge.
      state_d  = ERROR;
      tvalid_d = 1'b0;
      tfirst_d = 1'b0;
      tlast_d  = 1'b0;
      err_d    = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, DONE, ERROR: begin
          if (start_i) begin
            state_d = LOAD;
            idx_d   = '0;
            addr_d  = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
          end
        end
        LOAD: state_d = LATCH;
        LATCH: begin
          state_d  = SEND;
          bcnt_d   = 2'd0;
          tvalid_d = 1'b1;
          tfirst_d = 1'b1;
          tlast_d  = 1'b0;
          tdata_d  = rom_data_i[MEM_WIDTH-1 -: DATA_WIDTH];
        end
        SEND: begin
          if (m.tvalid && m.tready) begin
            unique case (bcnt_q)
              2'd0: begin
                tdata_d  = word_q[2*DATA_WIDTH-1 -: DATA_WIDTH];
                tfirst_d = 1'b0;
                bcnt_d   = 2'd1;
              end
              2'd1: begin
                tdata_d = word_q[DATA_WIDTH-1:0];
                tlast_d = 1'b1;
                bcnt_d  = 2'd2;
              end
              default: begin
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
`ifdef CFG_PAUSE_EN
                if (idx_q == PAUSE_IDX) begin
                  state_d = PAUSE;
                  pcnt_d  = PAUSE_LOAD;
                end else begin
                  word_end = 1'b1;
                end
`else
                word_end = 1'b1;
`endif
              end
            endcase
          end
        end
`ifdef CFG_PAUSE_EN
        PAUSE: begin
          if (pcnt_q == 32'd0) word_end = 1'b1;
          else                 pcnt_d   = pcnt_q - 32'd1;
        end
`endif
        default: state_d = IDLE;
      endcase
      // A word (and its pause, if any) is finished: stop or fetch the next one.
      if (word_end) begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 1'b1;
          addr_d  = idx_q + 1'b1;
          state_d = LOAD;
        end
      end
    end
  end

  // Control and output registers; reset drops everything to the idle state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rom_addr_o <= '0;
      bcnt_q     <= 2'd0;
      m.tdata    <= '0;
      m.tvalid   <= 1'b0;
      m.tfirst   <= 1'b0;
      m.tlast    <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rom_addr_o <= addr_d;
      bcnt_q     <= bcnt_d;
      m.tdata    <= tdata_d;
      m.tvalid   <= tvalid_d;
      m.tfirst   <= tfirst_d;
      m.tlast    <= tlast_d;
      done_o     <= done_d;
      err_o      <= err_d;
    end
  end

  // Word register: captures the ROM entry for the bytes that follow the first.
  always_ff @(posedge clk_i) begin
    if (state_q == LATCH) word_q <= rom_data_i;
  end

`ifdef CFG_PAUSE_EN
  // Settle-pause down-counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pcnt_q <= 32'd0;
    else       pcnt_q <= pcnt_d;
  end
`endif

endmodule

// File: tb/tb_si5340_cfg_sequencer.sv
// tb_si5340_cfg_sequencer: directed scenarios with randomized back-pressure,
// checked against a byte-level model of the configuration stream.
`timescale 1ns/1ps
module tb_si5340_cfg_sequencer;
  localparam int PCYC = 10;
`ifdef CFG_PAUSE_EN
  localparam int EP = PCYC;
`else
  localparam int EP = 0;
`endif

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, tready = 1'b0, nack = 1'b0, sel = 1'b0;
  int   cyc = 0;
  int   checks = 0, failures = 0;
  int   cur_nw = 4, cur_pw = 1, start_cyc = 0, idle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [23:0] rom_tbl [0:3];
  logic [1:0]  addr4;
  logic [0:0]  addr1;
  logic [23:0] rd4, rd1;
  always @(posedge clk) begin
    rd4 <= rom_tbl[addr4];
    rd1 <= rom_tbl[{1'b0, addr1}];
  end

  si5340_cfg_sequencer_if #(.DATA_WIDTH(8)) bus4 ();
  si5340_cfg_sequencer_if #(.DATA_WIDTH(8)) bus1 ();
  assign bus4.tready = tready & ~sel;
  assign bus4.nack   = nack & ~sel;
  assign bus1.tready = tready & sel;
  assign bus1.nack   = nack & sel;

  logic busy4, done4, err4, busy1, done1, err1;

  si5340_cfg_sequencer #(.MEM_WIDTH(24), .DATA_WIDTH(8), .WORD_NUMBER(4), .ADDR_W(2),
                         .PAUSE_AFTER_WORD(1), .PAUSE_CYCLES(PCYC)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start & ~sel), .rom_addr_o(addr4), .rom_data_i(rd4),
    .m(bus4), .busy_o(busy4), .done_o(done4), .err_o(err4));

  si5340_cfg_sequencer #(.MEM_WIDTH(24), .DATA_WIDTH(8), .WORD_NUMBER(1), .ADDR_W(1),
                         .PAUSE_AFTER_WORD(0), .PAUSE_CYCLES(PCYC)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start & sel), .rom_addr_o(addr1), .rom_data_i(rd1),
    .m(bus1), .busy_o(busy1), .done_o(done1), .err_o(err1));

  logic       o_tvalid, o_tfirst, o_tlast, o_busy, o_done, o_err;
  logic [7:0] o_tdata;
  logic [1:0] o_addr;
  always_comb begin
    if (sel) begin
      o_tvalid = bus1.tvalid; o_tfirst = bus1.tfirst; o_tlast = bus1.tlast; o_tdata = bus1.tdata;
      o_busy = busy1; o_done = done1; o_err = err1; o_addr = {1'b0, addr1};
    end else begin
      o_tvalid = bus4.tvalid; o_tfirst = bus4.tfirst; o_tlast = bus4.tlast; o_tdata = bus4.tdata;
      o_busy = busy4; o_done = done4; o_err = err4; o_addr = addr4;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Byte g of the stream: word g/3, bytes taken MSB first.
  function automatic logic [7:0] exp_byte(input int g);
    logic [23:0] w;
    w = rom_tbl[g / 3];
    return 8'(w >> (16 - 8 * (g % 3)));
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_tvalid"}, o_tvalid, 0);
    chk({tag, "_tfirst"}, o_tfirst, 0);
    chk({tag, "_tlast"},  o_tlast, 0);
    chk({tag, "_tdata"},  o_tdata, 0);
    chk({tag, "_addr"},   o_addr, 0);
    chk({tag, "_busy"},   o_busy, 0);
    chk({tag, "_done"},   o_done, 0);
    chk({tag, "_err"},    o_err, 0);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    idle = 0;
    @(negedge clk);
    start = 1'b0;
    chk("load_tvalid", o_tvalid, 0);
    chk("load_busy", o_busy, 1);
    chk("load_done_clr", o_done, 0);
    chk("load_err_clr", o_err, 0);
    chk("load_addr", o_addr, 0);
    @(negedge clk);
    chk("latch_tvalid", o_tvalid, 0);
  endtask

  // Take stream bytes [from, to) with stall_pct percent back-pressure.
  task automatic run_stream(input int from, input int to, input int stall_pct);
    int got = from;
    int n = 0;
    bit stalled = 0;
    logic [7:0] hd = '0;
    logic hf = 1'b0, hl = 1'b0;
    while (got < to && n < 400) begin
      @(negedge clk);
      n++;
      if (stalled) begin
        chk("stall_tvalid", o_tvalid, 1);
        chk("stall_tdata", o_tdata, hd);
        chk("stall_tfirst", o_tfirst, hf);
        chk("stall_tlast", o_tlast, hl);
      end
      if (from == 0 && n == 1) chk("tvalid_start_plus3", o_tvalid, 1);
      stalled = 0;
      tready = ($urandom_range(0, 99) >= stall_pct);
      if (o_tvalid) begin
        if (tready) begin
          chk("byte_data", o_tdata, exp_byte(got));
          chk("byte_first", o_tfirst, (got % 3) == 0);
          chk("byte_last", o_tlast, (got % 3) == 2);
          if ((got % 3) == 0 && got > 0)
            chk("word_gap", idle, 2 + (((got / 3) - 1) == cur_pw ? EP : 0));
          if (got == 3 * cur_nw - 1) chk("done_before_end", o_done, 0);
          idle = 0;
          got++;
        end else begin
          stalled = 1;
          hd = o_tdata; hf = o_tfirst; hl = o_tlast;
        end
      end else begin
        idle++;
      end
    end
    if (got < to) chk("stream_timeout", got, to);
  endtask

  // extra < 0 skips the latency check (random stalls).
  task automatic wait_done(input string tag, input int extra);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_done && n < 100);
    chk({tag, "_done_wait"}, n, 1 + ((cur_pw == cur_nw - 1) ? EP : 0));
    if (extra >= 0) chk({tag, "_latency"}, cyc - start_cyc, 5 * cur_nw + EP + 1 + extra);
    chk({tag, "_done"}, o_done, 1);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_tvalid"}, o_tvalid, 0);
    chk({tag, "_err"}, o_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rom_tbl[0] = 24'h0B24C0;
    rom_tbl[1] = 24'h0B2500;
    rom_tbl[2] = 24'h0A0104;
    rom_tbl[3] = 24'h0AFF55;

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    chk_zero("rst4");
    sel = 1'b1;
    #1 chk_zero("rst1");
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Full run, ready held high.
    cur_nw = 4; cur_pw = 1;
    do_start();
    run_stream(0, 12, 0);
    wait_done("a", 0);
    @(negedge clk);
    chk("done_hold", o_done, 1);

    // Same ROM with random back-pressure.
    do_start();
    run_stream(0, 12, 50);
    wait_done("b", -1);

    // NACK on the second byte of word 2, then restart.
    do_start();
    run_stream(0, 7, 30);
    @(negedge clk);
    chk("nack_pre_tvalid", o_tvalid, 1);
    chk("nack_pre_byte", o_tdata, exp_byte(7));
    nack = 1'b1;
    tready = 1'b1;
    @(negedge clk);
    nack = 1'b0;
    chk("nack_tvalid", o_tvalid, 0);
    chk("nack_err", o_err, 1);
    chk("nack_busy", o_busy, 0);
    chk("nack_tfirst", o_tfirst, 0);
    chk("nack_tlast", o_tlast, 0);
    chk("nack_done", o_done, 0);
    repeat (3) @(negedge clk);
    chk("nack_err_hold", o_err, 1);
    chk("nack_tvalid_hold", o_tvalid, 0);
    do_start();
    run_stream(0, 12, 0);
    wait_done("c", 0);

    // Asynchronous reset mid-run, then replay from word 0.
    do_start();
    run_stream(0, 6, 0);
`ifdef CFG_PAUSE_EN
    repeat (5) @(negedge clk);
    chk("rst_pre_busy", o_busy, 1);
    chk("rst_pre_tvalid", o_tvalid, 0);
`else
    @(negedge clk);
    tready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pre_busy", o_busy, 1);
    chk("rst_pre_tvalid", o_tvalid, 1);
`endif
    #1 rst = 1'b1;
    #1 chk_zero("rst_async");
    @(negedge clk);
    rst = 1'b0;
    do_start();
    run_stream(0, 12, 0);
    wait_done("d", 0);

    // start_i during SEND is ignored.
    do_start();
    run_stream(0, 4, 0);
    @(negedge clk);
    tready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("poke_addr", o_addr, 1);
    chk("poke_tvalid", o_tvalid, 1);
    chk("poke_byte", o_tdata, exp_byte(4));
    run_stream(4, 12, 0);
    wait_done("e", 2);

    // Single-word ROM whose only word is also the pause word.
    sel = 1'b1;
    cur_nw = 1; cur_pw = 0;
    do_start();
    run_stream(0, 3, 0);
    wait_done("f", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
